// File: rtl/mem_mmio_bus.sv
// Memory/peripheral slave for the multicycle core: byte-maskable RAM, UART TX with FIFO,
// free-running cycle counter. Reads are registered (1-clock latency), bus_err is sticky.
module mem_mmio_bus #(
    parameter int MEM_WORDS  = 4096,
    parameter     INIT_FILE  = "",
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic [3:0]  WriteMask,
    output logic [31:0] ReadData,
    output logic        uart_tx,
    output logic        bus_err
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [31:0]      RAM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [31:0]      ADDR_TX   = 32'h1000_0000;
    localparam logic [31:0]      ADDR_STAT = 32'h1000_0004;
    localparam logic [31:0]      ADDR_CYC  = 32'h1000_0008;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       FIFO_MAX  = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    logic [31:0]      mem [MEM_WORDS];
    logic [7:0]       fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [3:0]       count;
    logic             overflow;
    logic [31:0]      cycle;
    logic [31:0]      read_next;

    uart_state_t      state, state_next;
    logic [DIV_W-1:0] div_cnt, div_next;
    logic [2:0]       bit_cnt, bit_next;
    logic [7:0]       shift, shift_next;
    logic             tx_next, pop;

    logic             sel_ram, sel_tx, sel_stat, sel_cyc, mapped;
    logic [IDX_W-1:0] word_idx;
    logic             fifo_full, fifo_empty, push_req, push, clear_ovf;

    assign sel_ram    = (Address[31:28] == 4'h0) && ({4'h0, Address[27:0]} < RAM_BYTES);
    assign sel_tx     = (Address == ADDR_TX);
    assign sel_stat   = (Address == ADDR_STAT);
    assign sel_cyc    = (Address == ADDR_CYC);
    assign mapped     = sel_ram | sel_tx | sel_stat | sel_cyc;
    assign word_idx   = Address[IDX_W+1:2];

    assign fifo_full  = (count == FIFO_MAX);
    assign fifo_empty = (count == 4'd0);
    assign push_req   = MemWrite && WriteMask[0] && sel_tx;
    assign push       = push_req && !fifo_full;
    assign clear_ovf  = MemWrite && WriteMask[0] && WriteData[3] && sel_stat;

    always_ff @(posedge clk) begin
        if (MemWrite && sel_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (WriteMask[i]) mem[word_idx][8*i +: 8] <= WriteData[8*i +: 8];
            end
        end
    end

    always_comb begin
        read_next = '0;
        if (sel_ram)       read_next = mem[word_idx];
        else if (sel_stat) read_next = {24'h0, count, overflow, fifo_full, fifo_empty, state != IDLE};
        else if (sel_cyc)  read_next = cycle;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ReadData <= '0;
            bus_err  <= 1'b0;
            cycle    <= '0;
        end else begin
            ReadData <= read_next;
            cycle    <= cycle + 32'd1;
            if (!mapped) bus_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= WriteData[7:0];
    end

    // Fullness uses the count before the edge, so a push into a full FIFO drops even if a pop frees a slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (push_req && fifo_full) overflow <= 1'b1;
            else if (clear_ovf)        overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_next;
            div_cnt <= div_next;
            bit_cnt <= bit_next;
            shift   <= shift_next;
            uart_tx <= tx_next;
        end
    end

    // The line value is registered alongside the state, so each bit appears on the edge that enters it
    always_comb begin
        state_next = state;
        div_next   = div_cnt + 1'b1;
        bit_next   = bit_cnt;
        shift_next = shift;
        tx_next    = uart_tx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                div_next = '0;
                bit_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo[rd_ptr];
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (div_cnt == DIV_LAST) begin
                    state_next = DATA;
                    div_next   = '0;
                    bit_next   = '0;
                    tx_next    = shift[0];
                end
            end
            DATA: begin
                if (div_cnt == DIV_LAST) begin
                    div_next = '0;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                        bit_next   = '0;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_cnt + 3'd1;
                        shift_next = {1'b0, shift[7:1]};
                        tx_next    = shift[1];
                    end
                end
            end
            STOP: begin
                if (div_cnt == DIV_LAST) begin
                    state_next = IDLE;
                    div_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_mmio_bus.sv
// Directed bench for mem_mmio_bus: vector table for RAM/register reads, hand sequences for
// UART framing, FIFO overflow, cycle counter, bus errors and asynchronous reset.
module tb_mem_mmio_bus;
    localparam int CLK_DIV = 4;
    localparam logic [31:0] A_TX   = 32'h1000_0000;
    localparam logic [31:0] A_STAT = 32'h1000_0004;
    localparam logic [31:0] A_CYC  = 32'h1000_0008;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic [3:0]  WriteMask = '0;
    logic [31:0] ReadData;
    logic        uart_tx;
    logic        bus_err;

    int n_compared = 0;
    int n_mismatched = 0;
    logic [7:0] rx_q[$];
    int rx_bad = 0;
    logic mon_en = 1'b1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  mask;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    mem_mmio_bus #(.MEM_WORDS(1024), .INIT_FILE(""), .FIFO_DEPTH(8), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset_n(reset_n), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .WriteMask(WriteMask), .ReadData(ReadData),
        .uart_tx(uart_tx), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one bus cycle, lets the edge happen, and returns 1 time unit later with the store strobe dropped
    task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic we, input logic [3:0] mask);
        Address   = addr;
        WriteData = wdata;
        MemWrite  = we;
        WriteMask = mask;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
        WriteMask = '0;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        int j = k / CLK_DIV;
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    // Independent receiver: samples each bit in the middle of its CLK_DIV window
    initial begin
        logic [7:0] b;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && reset_n && uart_tx === 1'b0) begin
                repeat (CLK_DIV + CLK_DIV/2) @(posedge clk);
                #1;
                b[0] = uart_tx;
                for (int i = 1; i < 8; i++) begin
                    repeat (CLK_DIV) @(posedge clk);
                    #1;
                    b[i] = uart_tx;
                end
                repeat (CLK_DIV) @(posedge clk);
                #1;
                if (uart_tx !== 1'b1) rx_bad++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] v1, v2;
        logic        ok;
        logic [7:0]  exp_rx[10];

        vecs[0]  = '{32'h100,  32'hAABBCCDD, 1'b1, 4'hF, 1'b0, 32'h0};
        vecs[1]  = '{32'h100,  32'h0000EE00, 1'b1, 4'h2, 1'b1, 32'hAABBCCDD};
        vecs[2]  = '{32'h100,  32'h0,        1'b0, 4'h0, 1'b1, 32'hAABBEEDD};
        vecs[3]  = '{32'h104,  32'h11223344, 1'b1, 4'hF, 1'b0, 32'h0};
        vecs[4]  = '{32'h104,  32'hFFFFFFFF, 1'b1, 4'h0, 1'b1, 32'h11223344};
        vecs[5]  = '{32'h104,  32'h99000000, 1'b1, 4'h8, 1'b1, 32'h11223344};
        vecs[6]  = '{32'h104,  32'h0,        1'b0, 4'h0, 1'b1, 32'h99223344};
        vecs[7]  = '{32'h108,  32'h0,        1'b1, 4'hF, 1'b0, 32'h0};
        vecs[8]  = '{32'h108,  32'h12345678, 1'b1, 4'h5, 1'b1, 32'h0};
        vecs[9]  = '{32'h108,  32'h0,        1'b0, 4'h0, 1'b1, 32'h00340078};
        vecs[10] = '{32'hFFC,  32'hDEADBEEF, 1'b1, 4'hF, 1'b0, 32'h0};
        vecs[11] = '{32'hFFC,  32'h0,        1'b0, 4'h0, 1'b1, 32'hDEADBEEF};
        vecs[12] = '{A_STAT,   32'h0,        1'b0, 4'h0, 1'b1, 32'h00000002};
        vecs[13] = '{A_TX,     32'h0,        1'b0, 4'h0, 1'b1, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_readdata", ReadData, 32'h0);
        check_output("reset_uart_tx", {31'h0, uart_tx}, 32'h1);
        check_output("reset_bus_err", {31'h0, bus_err}, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].mask);
            if (vecs[i].chk) check_output($sformatf("vec%0d", i), ReadData, vecs[i].exp);
        end
        check_output("no_bus_err_after_table", {31'h0, bus_err}, 32'h0);

        // Single 0x55 frame, checked cycle by cycle
        apply_stimulus(A_TX, 32'h55, 1'b1, 4'h1);
        check_output("tx_idle_at_push_edge", {31'h0, uart_tx}, 32'h1);
        Address = A_STAT;
        for (int k = 0; k < 10*CLK_DIV; k++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("frame_bit_k%0d", k), {31'h0, uart_tx}, {31'h0, frame_bit(8'h55, k)});
            if (k == 20) check_output("busy_mid_frame", {31'h0, ReadData[0]}, 32'h1);
        end
        repeat (2) @(posedge clk);
        #1;
        check_output("status_after_frame", ReadData, 32'h00000002);
        check_output("tx_idle_after_frame", {31'h0, uart_tx}, 32'h1);

        // Ten back-to-back pushes: first pops on the next edge, tenth finds the FIFO full
        for (int i = 0; i < 10; i++) apply_stimulus(A_TX, 32'hA0 + i, 1'b1, 4'h1);
        apply_stimulus(A_STAT, 32'h0, 1'b0, 4'h0);
        check_output("status_full_overflow", ReadData, 32'h0000008D);
        apply_stimulus(A_STAT, 32'h08, 1'b1, 4'h1);
        check_output("status_on_clear_edge", ReadData, 32'h0000008D);
        apply_stimulus(A_STAT, 32'h0, 1'b0, 4'h0);
        check_output("status_overflow_cleared", ReadData, 32'h00000085);
        ok = 1'b0;
        for (int n = 0; n < 1000 && !ok; n++) begin
            @(posedge clk);
            #1;
            if (ReadData == 32'h2) ok = 1'b1;
        end
        check_output("fifo_drained", {31'h0, ok}, 32'h1);
        exp_rx[0] = 8'h55;
        for (int i = 0; i < 9; i++) exp_rx[i+1] = 8'hA0 + 8'(i);
        check_output("rx_count", rx_q.size(), 32'd10);
        check_output("rx_stop_bits", rx_bad, 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (i < rx_q.size()) check_output($sformatf("rx_byte%0d", i), {24'h0, rx_q[i]}, {24'h0, exp_rx[i]});
        end

        // Cycle counter
        apply_stimulus(A_CYC, 32'h0, 1'b0, 4'h0);
        v1 = ReadData;
        repeat (5) @(posedge clk);
        #1;
        v2 = ReadData;
        check_output("cycle_delta5", v2 - v1, 32'd5);
        apply_stimulus(A_CYC, 32'h0, 1'b1, 4'hF);
        check_output("cycle_write_edge", ReadData, v2 + 32'd1);
        apply_stimulus(A_CYC, 32'h0, 1'b0, 4'h0);
        check_output("cycle_write_ignored", ReadData, v2 + 32'd2);

        // Unmapped and out-of-range accesses
        apply_stimulus(32'h100, 32'h0, 1'b0, 4'h0);
        check_output("ram_before_unmapped", ReadData, 32'hAABBEEDD);
        check_output("bus_err_before_unmapped", {31'h0, bus_err}, 32'h0);
        apply_stimulus(32'h2000_0000, 32'h0, 1'b0, 4'h0);
        check_output("unmapped_read_zero", ReadData, 32'h0);
        check_output("bus_err_set", {31'h0, bus_err}, 32'h1);
        apply_stimulus(32'h1100, 32'h12121212, 1'b1, 4'hF);
        check_output("out_of_range_read_zero", ReadData, 32'h0);
        apply_stimulus(32'h100, 32'h0, 1'b0, 4'h0);
        check_output("ram_intact_after_oor_write", ReadData, 32'hAABBEEDD);
        apply_stimulus(32'h1000_000C, 32'h0, 1'b0, 4'h0);
        check_output("unmapped_reg_read_zero", ReadData, 32'h0);
        apply_stimulus(32'h104, 32'h0, 1'b0, 4'h0);
        check_output("ram_after_unmapped", ReadData, 32'h99223344);
        check_output("bus_err_sticky", {31'h0, bus_err}, 32'h1);

        // Reset during a start bit, with one byte still queued
        mon_en = 1'b0;
        apply_stimulus(A_TX, 32'h00, 1'b1, 4'h1);
        apply_stimulus(A_TX, 32'h11, 1'b1, 4'h1);
        apply_stimulus(32'h100, 32'h0, 1'b0, 4'h0);
        check_output("start_bit_on_line", {31'h0, uart_tx}, 32'h0);
        check_output("readdata_before_reset", ReadData, 32'hAABBEEDD);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("async_reset_uart_tx", {31'h0, uart_tx}, 32'h1);
        check_output("async_reset_readdata", ReadData, 32'h0);
        check_output("async_reset_bus_err", {31'h0, bus_err}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        apply_stimulus(A_STAT, 32'h0, 1'b0, 4'h0);
        check_output("status_after_reset", ReadData, 32'h00000002);
        check_output("tx_idle_after_reset", {31'h0, uart_tx}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
